// File: rtl/sd_spi_cmd_master.sv
// ============================================================================
// Module   : sd_spi_cmd_master
// Purpose  : SPI-mode SD command initiator. It sends the 6-byte command frame
//            on SPI mode 0, polls for R1 and can read a 4-byte R3/R7 tail.
// Options  : define SD_SPI_CMD_CRC7_EN to compute the CRC7 serially while
//            the frame is shifted out; otherwise a fixed CRC table is used.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_spi_cmd_master #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_long,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        resp_timeout,
  output logic        sd_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_PW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
  localparam logic [c_PW-1:0] c_POLL_MAX = c_PW'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_R1  = 3'd2,
    S_READ_EXT = 3'd3,
    S_TRAIL    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          r_state;
  logic [c_DW-1:0] r_div;
  logic [47:0]     r_sh;
  logic [7:0]      r_rx;
  logic [2:0]      r_bit;
  logic [2:0]      r_byte;
  logic [c_PW-1:0] r_poll;
  logic            r_long;
  logic [7:0]      r_r1;
  logic [31:0]     r_ext;
  logic            r_to;

  logic            w_shifting;
  logic            w_tick;
  logic            w_rise;
  logic            w_fall;
  logic            w_byte_end;
  logic [c_PW-1:0] w_poll_next;
  logic [7:0]      w_byte5;

  assign w_shifting  = (r_state == S_SEND) || (r_state == S_WAIT_R1) ||
                       (r_state == S_READ_EXT) || (r_state == S_TRAIL);
  assign w_tick      = w_shifting && (r_div == c_DIV_LAST);
  assign w_rise      = w_tick && !spi_clk;
  assign w_fall      = w_tick && spi_clk;
  assign w_byte_end  = w_fall && (r_bit == 3'd7);
  assign w_poll_next = r_poll + c_PW'(1);

`ifdef SD_SPI_CMD_CRC7_EN
  logic [6:0] r_crc;
  logic [6:0] w_crc_upd;

  // The bit currently on the wire is r_sh[47]; fold it in at its falling edge.
  assign w_crc_upd = {r_crc[5:0], 1'b0} ^ ({7{r_crc[6] ^ r_sh[47]}} & 7'h09);
  assign w_byte5   = 8'hFF;
`else
  function automatic logic [7:0] f_crc_table(input logic [5:0] idx);
    case (idx)
      6'd0:    f_crc_table = 8'h95;
      6'd8:    f_crc_table = 8'h87;
      default: f_crc_table = 8'h01;
    endcase
  endfunction

  assign w_byte5 = f_crc_table(cmd_idx);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_sh         <= '1;
      r_rx         <= '1;
      r_bit        <= '0;
      r_byte       <= '0;
      r_poll       <= '0;
      r_long       <= 1'b0;
      r_r1         <= 8'hFF;
      r_ext        <= '0;
      r_to         <= 1'b0;
      cmd_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_r1      <= 8'hFF;
      resp_ext     <= '0;
      resp_timeout <= 1'b0;
      sd_cs        <= 1'b1;
      spi_clk      <= 1'b0;
      spi_mosi     <= 1'b1;
`ifdef SD_SPI_CMD_CRC7_EN
      r_crc        <= '0;
`endif
    end else begin
      if (w_shifting) begin
        r_div <= w_tick ? '0 : r_div + c_DW'(1);
      end

      if (w_rise) begin
        spi_clk <= 1'b1;
        r_rx    <= {r_rx[6:0], spi_miso};
      end

      // Once the frame has drained, ones refill the shifter so the poll bytes are 0xFF.
      if (w_fall) begin
        spi_clk  <= 1'b0;
        r_bit    <= r_bit + 3'd1;
        spi_mosi <= r_sh[46];
        r_sh     <= {r_sh[46:0], 1'b1};
`ifdef SD_SPI_CMD_CRC7_EN
        if ((r_state == S_SEND) && (r_byte <= 3'd4)) begin
          r_crc <= w_crc_upd;
          if ((r_byte == 3'd4) && (r_bit == 3'd7)) begin
            spi_mosi    <= w_crc_upd[6];
            r_sh[47:40] <= {w_crc_upd, 1'b1};
          end
        end
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            sd_cs     <= 1'b0;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            r_sh      <= {2'b01, cmd_idx, cmd_arg, w_byte5};
            r_long    <= cmd_long;
            r_div     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_poll    <= '0;
            r_r1      <= 8'hFF;
            r_ext     <= '0;
            r_to      <= 1'b0;
`ifdef SD_SPI_CMD_CRC7_EN
            r_crc     <= '0;
`endif
            r_state   <= S_SEND;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_SEND: begin
          if (w_byte_end) begin
            r_byte <= r_byte + 3'd1;
            if (r_byte == 3'd5) begin
              r_poll  <= '0;
              r_state <= S_WAIT_R1;
            end
          end
        end

        S_WAIT_R1: begin
          if (w_byte_end) begin
            if (!r_rx[7]) begin
              r_r1    <= r_rx;
              r_byte  <= '0;
              r_state <= r_long ? S_READ_EXT : S_TRAIL;
            end else if (w_poll_next == c_POLL_MAX) begin
              r_to    <= 1'b1;
              r_r1    <= 8'hFF;
              r_state <= S_TRAIL;
            end else begin
              r_poll  <= w_poll_next;
            end
          end
        end

        S_READ_EXT: begin
          if (w_byte_end) begin
            r_ext  <= {r_ext[23:0], r_rx};
            r_byte <= r_byte + 3'd1;
            if (r_byte == 3'd3) begin
              r_state <= S_TRAIL;
            end
          end
        end

        S_TRAIL: begin
          if (w_byte_end) begin
            sd_cs        <= 1'b1;
            resp_valid   <= 1'b1;
            resp_r1      <= r_r1;
            resp_ext     <= r_ext;
            resp_timeout <= r_to;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_cmd_master.sv
// ============================================================================
// Module   : tb_sd_spi_cmd_master
// Purpose  : directed bench for sd_spi_cmd_master with a simple SD card model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_cmd_master;

  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_long = 1'b0;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic        resp_timeout;
  logic        sd_cs;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b1;

  sd_spi_cmd_master #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_long(cmd_long),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_ext(resp_ext),
    .resp_timeout(resp_timeout),
    .sd_cs(sd_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Card model: reply bytes start card_delay bytes after the 6-byte command.
  int         card_delay = 0;
  int         card_len   = 0;
  logic [7:0] card_reply [5];
  int         rise_cnt = 0;
  int         last_rise_cyc = 0;
  int         bad_period = 0;
  int         cyc = 0;
  logic [7:0] mosi_sh = '0;
  logic [7:0] mosi_q [$];

  function automatic logic card_bit(input int n);
    int k;
    k = n / 8 - 6 - card_delay;
    if (k >= 0 && k < card_len) return card_reply[k][7 - (n % 8)];
    return 1'b1;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge spi_clk or posedge sd_cs) begin
    if (sd_cs) begin
      rise_cnt = 0;
    end else begin
      if (rise_cnt > 0 && (cyc - last_rise_cyc) != 2 * CLK_DIV) bad_period++;
      last_rise_cyc = cyc;
      mosi_sh = {mosi_sh[6:0], spi_mosi};
      rise_cnt++;
      if (rise_cnt % 8 == 0) mosi_q.push_back(mosi_sh);
    end
  end

  always @(negedge clk) spi_miso <= sd_cs ? 1'b1 : card_bit(rise_cnt);

  int          resp_cnt = 0;
  logic [7:0]  cap_r1;
  logic [31:0] cap_ext;
  logic        cap_to;

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      cap_r1  = resp_r1;
      cap_ext = resp_ext;
      cap_to  = resp_timeout;
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                           input int dly, input int len, input logic [39:0] reply);
    for (int i = 0; i < 5; i++) card_reply[i] = reply[39 - 8 * i -: 8];
    card_delay = dly;
    card_len   = len;
    mosi_q.delete();
    resp_cnt   = 0;
    bad_period = 0;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; cmd_long = lng; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_idx = 6'h3F; cmd_arg = '1; cmd_long = ~lng;
  endtask

  task automatic finish_cmd(input string tag);
    for (int i = 0; i < 5000 && resp_cnt == 0; i++) @(negedge clk);
    check({tag, "_resp_seen"}, 64'(resp_cnt > 0), 64'd1);
    repeat (40) @(negedge clk);
    check({tag, "_resp_cnt"}, 64'(resp_cnt), 64'd1);
    check({tag, "_cs_idle"}, 64'(sd_cs), 64'd1);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp, input int nbytes);
    logic [47:0] f;
    logic        tail_ok;
    f = '0;
    tail_ok = 1'b1;
    for (int i = 0; i < mosi_q.size(); i++) begin
      if (i < 6) f = {f[39:0], mosi_q[i]};
      else if (mosi_q[i] != 8'hFF) tail_ok = 1'b0;
    end
    check({tag, "_nbytes"}, 64'(mosi_q.size()), 64'(nbytes));
    check({tag, "_frame"}, 64'(f), 64'(exp));
    check({tag, "_tail_ff"}, 64'(tail_ok), 64'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 64'(sd_cs), 64'd1);
    check("rst_sclk", 64'(spi_clk), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd1);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_r1", 64'(resp_r1), 64'hFF);
    check("rst_ext", 64'(resp_ext), 64'd0);
    check("rst_to", 64'(resp_timeout), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(cmd_ready), 64'd1);

    // CMD0, R1=0x01 after one 0xFF poll byte
    start_cmd(6'd0, 32'h0, 1'b0, 1, 1, 40'h01_00_00_00_00);
    finish_cmd("cmd0");
    check_frame("cmd0", 48'h40_0000_0000_95, 9);
    check("cmd0_r1", 64'(cap_r1), 64'h01);
    check("cmd0_to", 64'(cap_to), 64'd0);
    check("cmd0_ext", 64'(cap_ext), 64'd0);
    check("cmd0_period", 64'(bad_period), 64'd0);

    // CMD8 long, R7 = 01 000001AA
    start_cmd(6'd8, 32'h0000_01AA, 1'b1, 0, 5, 40'h01_00_00_01_AA);
    finish_cmd("cmd8");
    check_frame("cmd8", 48'h48_0000_01AA_87, 12);
    check("cmd8_r1", 64'(cap_r1), 64'h01);
    check("cmd8_ext", 64'(cap_ext), 64'h0000_01AA);
    check("cmd8_to", 64'(cap_to), 64'd0);

    // Card never answers: 8 polls then trail
    start_cmd(6'd8, 32'h0000_01AA, 1'b1, 0, 0, 40'h0);
    finish_cmd("tmo");
    check_frame("tmo", 48'h48_0000_01AA_87, 15);
    check("tmo_to", 64'(cap_to), 64'd1);
    check("tmo_r1", 64'(cap_r1), 64'hFF);
    check("tmo_ext", 64'(cap_ext), 64'd0);

    // R1 on the last allowed poll byte is a success
    start_cmd(6'd0, 32'h0, 1'b0, RESP_TIMEOUT - 1, 1, 40'h00_00_00_00_00);
    finish_cmd("last");
    check_frame("last", 48'h40_0000_0000_95, 15);
    check("last_to", 64'(cap_to), 64'd0);
    check("last_r1", 64'(cap_r1), 64'h00);

    // CMD17 arg 0
    start_cmd(6'd17, 32'h0, 1'b0, 0, 1, 40'h00_00_00_00_00);
    finish_cmd("cmd17");
`ifdef SD_SPI_CMD_CRC7_EN
    check_frame("cmd17", 48'h51_0000_0000_55, 8);
`else
    check_frame("cmd17", 48'h51_0000_0000_01, 8);
`endif

    // Reset during SEND at bit 20
    start_cmd(6'd0, 32'h0, 1'b0, 0, 1, 40'h01_00_00_00_00);
    for (int i = 0; i < 1000 && rise_cnt < 20; i++) @(negedge clk);
    check("mid_reached", 64'(rise_cnt >= 20), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_cs", 64'(sd_cs), 64'd1);
    check("mid_sclk", 64'(spi_clk), 64'd0);
    check("mid_mosi", 64'(spi_mosi), 64'd1);
    check("mid_valid", 64'(resp_valid), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("mid_ready", 64'(cmd_ready), 64'd1);
    check("mid_no_resp", 64'(resp_cnt), 64'd0);
    start_cmd(6'd0, 32'h0, 1'b0, 0, 1, 40'h01_00_00_00_00);
    finish_cmd("post_rst");
    check_frame("post_rst", 48'h40_0000_0000_95, 8);
    check("post_rst_r1", 64'(cap_r1), 64'h01);

    // Second request while waiting for R1 is ignored
    start_cmd(6'd8, 32'h0000_01AA, 1'b1, 3, 5, 40'h01_00_00_01_AA);
    for (int i = 0; i < 1000 && rise_cnt < 52; i++) @(negedge clk);
    check("busy_reached", 64'(rise_cnt >= 52), 64'd1);
    check("busy_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_idx = 6'd17; cmd_arg = 32'h1234_5678; cmd_long = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    finish_cmd("busy");
    check_frame("busy", 48'h48_0000_01AA_87, 15);
    check("busy_r1", 64'(cap_r1), 64'h01);
    check("busy_ext", 64'(cap_ext), 64'h0000_01AA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sd_spi_cmd_master.md
Name: sd_spi_cmd_master

Overview:
- SPI-mode SD command initiator: the host-side counterpart of the SD card emulator used in simulation.
- Accepts a command index plus a 32-bit argument on a valid/ready handshake, serialises the 6-byte SD command frame on SPI mode 0, and polls for the R1 response.
- Optionally reads a 4-byte extended response (R3/R7), then returns the result with a one-cycle valid strobe.
- Sits between the CPU-facing SD register block and the sd_cs/spi_clk/spi_mosi/spi_miso pins.

Parameters:
- CLK_DIV, 2, clk cycles per spi_clk half-period; legal range ≥1. One SPI bit takes 2*CLK_DIV clk cycles.
- RESP_TIMEOUT, 8, maximum number of 0xFF poll bytes clocked while waiting for R1 (the NCR limit).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_idx  in  6  SD command index.
- cmd_arg  in  32  command argument.
- cmd_long  in  1  expect R1 plus 4 extra bytes (R3/R7).
- resp_valid  out  1  one-cycle strobe when the transaction completes.
- resp_r1  out  8  R1 byte; 0xFF on timeout.
- resp_ext  out  32  extra bytes, MSB first; 0 if cmd_long=0 or on timeout.
- resp_timeout  out  1  valid alongside resp_valid.
- sd_cs  out  1  chip select, active-low.
- spi_clk  out  1  SPI clock; idle low.
- spi_mosi  out  1  master out; idles high.
- spi_miso  in  1  slave in.

Behaviour:
- Reset (rst=0 at a clk edge) values: sd_cs=1, spi_clk=0, spi_mosi=1, cmd_ready=0 during reset then 1 in IDLE, resp_valid=0, resp_r1=8'hFF, resp_ext=0, resp_timeout=0.
- Reset mid-transaction aborts immediately. On the first edge with rst=0, sd_cs returns high and spi_clk low, with no partial resp_valid.
- SPI mode 0:
  - spi_mosi changes while spi_clk is low; it is updated at each falling edge and at frame start.
  - spi_miso is sampled on the clk cycle where spi_clk rises.
  - All bytes are MSB first.
  - A divider counter toggles spi_clk every CLK_DIV cycles while in a shifting state.
- Frame format:
  - byte0 = {2'b01, cmd_idx}
  - bytes 1–4 = cmd_arg[31:0] big-endian
  - byte5 = {crc7, 1'b1}
- Inputs are latched at acceptance; later changes to the inputs have no effect.
- State machine:
  - IDLE: cmd_ready=1. On accept, latch inputs, drive sd_cs=0, load byte0, go to SEND.
  - SEND: shift 48 bits; after the last bit's rising edge, go to WAIT_R1 with poll counter=0.
  - WAIT_R1: clock out 0xFF bytes. After each byte:
    - If the received byte has bit7=0, latch it into resp_r1 and go to READ_EXT if cmd_long, else TRAIL.
    - Else increment the poll counter. If it reaches RESP_TIMEOUT, set timeout, set r1=0xFF, go to TRAIL.
  - READ_EXT: clock 4 bytes of 0xFF, shifting spi_miso into resp_ext; then go to TRAIL.
  - TRAIL: clock one 0xFF byte (8 clocks) with sd_cs still low, then drive sd_cs=1 and go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE. resp_* hold their values until the next DONE.
- cmd_valid while busy is ignored; no queuing.
- A byte boundary is detected by a 3-bit bit counter wrapping from 7 to 0. The poll counter is $clog2(RESP_TIMEOUT+1) bits wide.
- An R1 found on the final allowed poll byte is a success, not a timeout.

Optional Feature:
- Macro: SD_SPI_CMD_CRC7_EN.
- Defined: crc7 uses polynomial x^7+x^3+1 with a zero initial value, computed serially over the 40 bits of bytes 0–4 while they are loaded or shifted. Byte5 is always a valid CRC byte.
- Undefined: byte5 comes from a fixed table, and no CRC logic is synthesised:
  - 0x95 when cmd_idx=0
  - 0x87 when cmd_idx=8
  - 0x01 otherwise

Test Plan:
- CMD0 (idx 0, arg 0, short), CLK_DIV=2, card replies 0x01 after 1 poll byte → MOSI bytes 40 00 00 00 00 95, then FF FF FF; resp_r1=0x01, resp_timeout=0; every spi_clk period is 4 clk cycles; sd_cs is low for exactly 9 bytes.
- CMD8 (idx 8, arg 0x000001AA, long), card replies 01 00 00 01 AA → MOSI bytes 48 00 00 01 AA 87; resp_r1=0x01, resp_ext=0x000001AA, resp_valid high for 1 cycle.
- spi_miso held high, RESP_TIMEOUT=8 → exactly 8 poll bytes then 1 trail byte; resp_timeout=1, resp_r1=0xFF, resp_ext=0.
- With SD_SPI_CMD_CRC7_EN, CMD17 arg 0 → byte5=0x55; CMD0 arg 0 still gives 0x95.
- Reset asserted mid-SEND (bit 20) → next edge: sd_cs=1, spi_clk=0, spi_mosi=1, resp_valid stays 0; after release, cmd_ready=1 and a new CMD0 completes normally.
- Second cmd_valid pulsed during WAIT_R1 → ignored (cmd_ready=0); only one resp_valid occurs, with data from the first command.
